// File: rtl/pwm_breath_sequencer.sv
// Breathing-LED sequencer: divides clk into step ticks, ramps a shared 8-bit
// duty up / hold / down / hold, and drives one registered PWM comparator per
// LED channel. Mode 0 lights all channels together, mode 1 chases one channel
// per breath.
module pwm_breath_sequencer #(
  parameter int unsigned CLK_DIV    = 6250000,
  parameter int unsigned STEP       = 1,
  parameter int unsigned HOLD_TICKS = 16,
  parameter int unsigned NUM_CH     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              mode,
  output logic [7:0]        duty,
  output logic [NUM_CH-1:0] ch_sel,
  output logic [NUM_CH-1:0] pwm,
  output logic              tick,
  output logic              cycle_done
);

  localparam int unsigned DivW  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned HoldW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;

  localparam logic [DivW-1:0]   DivLast  = DivW'(CLK_DIV - 1);
  localparam logic [DivW-1:0]   DivOne   = DivW'(1);
  localparam logic [HoldW-1:0]  HoldLast = HoldW'(HOLD_TICKS - 1);
  localparam logic [HoldW-1:0]  HoldOne  = HoldW'(1);
  localparam logic [8:0]        Step9    = 9'(STEP);
  localparam logic [7:0]        Step8    = 8'(STEP);
  localparam logic [NUM_CH-1:0] ChOne    = NUM_CH'(1);

  typedef enum logic [2:0] {
    StIdle,
    StUp,
    StHoldHi,
    StDown,
    StHoldLo
  } state_e;

  state_e              state_q, state_d;
  logic [DivW-1:0]     div_cnt_q;
  logic [HoldW-1:0]    hold_cnt_q, hold_cnt_d;
  logic [7:0]          duty_q, duty_d;
  logic [NUM_CH-1:0]   ch_sel_q, ch_sel_d;
  logic                cycle_done_q, cycle_done_d;
  logic [7:0]          pwm_cnt_q;
  logic [NUM_CH-1:0]   pwm_q;

  logic                tick_w;
  logic                ch_onehot;
  logic [NUM_CH-1:0]   ch_rot;
  logic [NUM_CH-1:0]   ch_next;
  logic [8:0]          duty_sum;

  // Step-tick divider; frozen while en is low so the phase survives a pause.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_q <= '0;
    end else if (en) begin
      div_cnt_q <= (div_cnt_q == DivLast) ? '0 : div_cnt_q + DivOne;
    end
  end

  assign tick_w = en && (div_cnt_q == DivLast);

  // Channel mask to use for the next breath, sampled from mode only at breath boundaries.
  always_comb begin
    ch_onehot = (ch_sel_q != '0) && ((ch_sel_q & (ch_sel_q - ChOne)) == '0);
    ch_rot    = (ch_sel_q << 1) | (ch_sel_q >> (NUM_CH - 1));
    if (!mode) begin
      ch_next = '1;
    end else if (ch_onehot) begin
      ch_next = ch_rot;
    end else begin
      // Coming from all-on (or reset), the chase restarts at channel 0.
      ch_next = ChOne;
    end
  end

  // Ramp FSM next-state: only moves on a step tick.
  always_comb begin
    state_d      = state_q;
    duty_d       = duty_q;
    hold_cnt_d   = hold_cnt_q;
    ch_sel_d     = ch_sel_q;
    cycle_done_d = 1'b0;
    // Nine bits so the saturation test sees the carry out of 8 bits.
    duty_sum     = {1'b0, duty_q} + Step9;

    if (tick_w) begin
      case (state_q)
        StIdle: begin
          ch_sel_d = ch_next;
          state_d  = StUp;
        end
        StUp: begin
          if (duty_sum >= 9'd255) begin
            duty_d     = 8'd255;
            hold_cnt_d = '0;
            state_d    = StHoldHi;
          end else begin
            duty_d = duty_sum[7:0];
          end
        end
        StHoldHi: begin
          if (hold_cnt_q == HoldLast) begin
            hold_cnt_d = '0;
            state_d    = StDown;
          end else begin
            hold_cnt_d = hold_cnt_q + HoldOne;
          end
        end
        StDown: begin
          if (duty_q <= Step8) begin
            duty_d     = 8'd0;
            hold_cnt_d = '0;
            state_d    = StHoldLo;
          end else begin
            duty_d = duty_q - Step8;
          end
        end
        StHoldLo: begin
          if (hold_cnt_q == HoldLast) begin
            hold_cnt_d   = '0;
            ch_sel_d     = ch_next;
            cycle_done_d = 1'b1;
            state_d      = StUp;
          end else begin
            hold_cnt_d = hold_cnt_q + HoldOne;
          end
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  // Ramp FSM state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      duty_q       <= '0;
      hold_cnt_q   <= '0;
      ch_sel_q     <= '0;
      cycle_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      duty_q       <= duty_d;
      hold_cnt_q   <= hold_cnt_d;
      ch_sel_q     <= ch_sel_d;
      cycle_done_q <= cycle_done_d;
    end
  end

  // Free-running PWM counter and registered per-channel comparators; ignores en
  // so the LEDs keep glowing at the frozen duty while paused.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_cnt_q <= '0;
      pwm_q     <= '0;
    end else begin
      pwm_cnt_q <= pwm_cnt_q + 8'd1;
      pwm_q     <= ch_sel_q & {NUM_CH{pwm_cnt_q < duty_q}};
    end
  end

  assign duty       = duty_q;
  assign ch_sel     = ch_sel_q;
  assign pwm        = pwm_q;
  assign tick       = tick_w;
  assign cycle_done = cycle_done_q;

endmodule

// File: doc/pwm_breath_sequencer.md
# pwm_breath_sequencer

Tick-driven sequencer that generates the breathing-LED duty ramp and shares it across NUM_CH PWM LED channels. It divides clk into a step tick and ramps an 8-bit duty up, holds, ramps down, holds, and repeats. Each channel gets a PWM comparator output. The block sits between the board clock and the LED pins and replaces the ad-hoc ramp/divider logic with one scheduled controller. In mode 0 every channel breathes together; in mode 1 channels take turns (chase).

## Interface
Parameters:
- CLK_DIV, 6250000, clk cycles per step tick; must be ≥2.
- STEP, 1, duty increment/decrement per tick; range 1..255.
- HOLD_TICKS, 16, ticks spent at each peak/trough; must be ≥1.
- NUM_CH, 4, number of LED channels; must be ≥1.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  run enable; low freezes divider and FSM.
- mode  in  1  0 = all channels together, 1 = chase.
- duty  out  8  current ramp level.
- ch_sel  out  NUM_CH  active-channel mask.
- pwm  out  NUM_CH  per-channel PWM, registered.
- tick  out  1  one-clk pulse per step tick.
- cycle_done  out  1  one-clk pulse at the end of each full breath.

## Operation
- Divider: div_cnt counts 0..CLK_DIV-1 and wraps. It advances only when en=1. tick=1 in the cycle when div_cnt==CLK_DIV-1 and en=1.
- The FSM updates only on tick. States:
  - IDLE: on tick, load ch_sel per mode and go to UP. duty stays 0.
  - UP: duty ← min(duty+STEP, 255). Compute in 9 bits, then saturate. If the result is 255, go to HOLD_HI and clear hold_cnt.
  - HOLD_HI: hold_cnt++. On the tick where hold_cnt==HOLD_TICKS-1, go to DOWN and clear hold_cnt.
  - DOWN: duty ← max(duty-STEP, 0). Saturate, with no underflow wrap. If the result is 0, go to HOLD_LO and clear hold_cnt.
  - HOLD_LO: on the tick where hold_cnt==HOLD_TICKS-1, pulse cycle_done, advance the channel, and go to UP.
- ch_sel load/advance:
  - mode=0: all ones.
  - mode=1 and ch_sel is one-hot: rotate left, with bit NUM_CH-1 wrapping to bit 0.
  - mode=1 otherwise: load 1 (channel 0).
- mode is sampled only at IDLE→UP and at the end of HOLD_LO. Changes mid-breath have no effect until then.
- PWM: the 8-bit pwm_cnt runs freely every clk regardless of en. Registered pwm[i] ← ch_sel[i] & (pwm_cnt < duty).
  - duty=0 gives constant low.
  - duty=255 gives high for 255 of every 256 clks.
- en=0: div_cnt, FSM, duty, hold_cnt and ch_sel are held. pwm keeps running at the frozen duty. tick stays 0.

## Timing
- Reset values: duty=0, ch_sel=0, pwm=0, tick=0, cycle_done=0, state=IDLE, div_cnt=0, hold_cnt=0, pwm_cnt=0.
- duty, state and ch_sel update on the clk edge that ends the tick cycle. They are visible the cycle after tick=1.
- cycle_done is asserted in the same cycle that duty enters its new UP phase (the cycle after the final HOLD_LO tick), for exactly one clk.
- pwm has 1-clk latency from pwm_cnt/duty/ch_sel.
- Breath length = ceil(255/STEP) + HOLD_TICKS + ceil(255/STEP) + HOLD_TICKS ticks. For the defaults this is 542 ticks. The first breath adds one extra tick for IDLE.
- rst asserted mid-operation forces all reset values immediately. After release, the sequence restarts from IDLE.

## Test plan
- CLK_DIV=4, STEP=1, HOLD_TICKS=2, mode=0, en=1 → tick every 4th clk. Expect:
  - duty ramps 0→255 in 255 ticks, holds 2 ticks, falls to 0, holds 2 ticks.
  - cycle_done pulses once after 1+514 ticks.
  - ch_sel=1111.
- STEP=100 → UP sequence 100, 200, 255, then HOLD_HI. DOWN sequence 155, 55, 0, then HOLD_LO. No wrap past 0 or 255.
- mode=1, NUM_CH=4 → ch_sel 0001, 0010, 0100, 1000, 0001 across successive cycle_done pulses. Toggling mode mid-breath leaves ch_sel unchanged until the boundary; mode 1→0 then gives 1111.
- Deassert en for 50 clks during UP → duty, div_cnt and state are frozen with no tick, and pwm still toggles. After re-enable, the ramp resumes from the same duty and the same div_cnt phase.
- PWM check with duty forced to 0 / 128 / 255 → over 256 clks, pwm[i] is high for 0 / 128 / 255 clks on selected channels and 0 on unselected ones.
- Assert rst while in HOLD_HI → next cycle, all outputs are at reset values. After release, IDLE→UP on the first tick.
